// File: rtl/regfile_2w2r_if.sv
// Bundle of the register-file write, read and status signals.
// The datapath side uses the master modport; the register file uses slave.
interface regfile_2w2r_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 2
);

    // Write port 0 (bit-masked)
    logic                 we0;
    logic [ADDR_BITS-1:0] waddr0;
    logic [WIDTH-1:0]     wdata0;
    logic [WIDTH-1:0]     wmask0;

    // Write port 1 (full width)
    logic                 we1;
    logic [ADDR_BITS-1:0] waddr1;
    logic [WIDTH-1:0]     wdata1;

    // Read ports
    logic [ADDR_BITS-1:0] raddr_a;
    logic [ADDR_BITS-1:0] raddr_b;
    logic [WIDTH-1:0]     rdata_a;
    logic [WIDTH-1:0]     rdata_b;

    // Registered status
    logic                 collision;
    logic                 oob_err;

    modport master (
        output we0,
        output waddr0,
        output wdata0,
        output wmask0,
        output we1,
        output waddr1,
        output wdata1,
        output raddr_a,
        output raddr_b,
        input  rdata_a,
        input  rdata_b,
        input  collision,
        input  oob_err
    );

    modport slave (
        input  we0,
        input  waddr0,
        input  wdata0,
        input  wmask0,
        input  we1,
        input  waddr1,
        input  wdata1,
        input  raddr_a,
        input  raddr_b,
        output rdata_a,
        output rdata_b,
        output collision,
        output oob_err
    );

endinterface

// File: rtl/regfile_2w2r.sv
// Two-write, two-read edge-triggered register file.
// Port 0 writes under a per-bit mask (so the flags register can share the
// array with A/X/Y/S); port 1 writes full width. Reads are combinational,
// with an optional bypass of this cycle's writes.
module regfile_2w2r #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       ADDR_BITS   = 2,
    parameter int unsigned       DEPTH       = 4,
    parameter bit                BYPASS      = 1'b1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic           clk,
    input  logic           reset,
    regfile_2w2r_if.slave  bus
);

    // Depth widened by one bit so the in-range compare never overflows.
    localparam logic [ADDR_BITS:0] LP_DEPTH = (ADDR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem  [DEPTH];
    logic [WIDTH-1:0] w_next [DEPTH];
    logic [WIDTH-1:0] w_view [DEPTH];

    logic w_in0;
    logic w_in1;
    logic w_in_a;
    logic w_in_b;
    logic w_wen0;
    logic w_wen1;
    logic w_collision;
    logic w_oob;
    logic r_collision;
    logic r_oob_err;

    logic [WIDTH-1:0] w_rdata_a;
    logic [WIDTH-1:0] w_rdata_b;

    // Address range decode for every port.
    always_comb begin
        w_in0  = ({1'b0, bus.waddr0}  < LP_DEPTH);
        w_in1  = ({1'b0, bus.waddr1}  < LP_DEPTH);
        w_in_a = ({1'b0, bus.raddr_a} < LP_DEPTH);
        w_in_b = ({1'b0, bus.raddr_b} < LP_DEPTH);
    end

    // Effective write enables; reset suppresses writes so the bypass view
    // matches the array contents while reset is held.
    always_comb begin
        w_wen0 = bus.we0 & w_in0 & ~reset;
        w_wen1 = bus.we1 & w_in1 & ~reset;
    end

    // Post-edge value of every entry. Port 1 is applied first and port 0's
    // masked merge on top, so on a shared entry port 0 wins where wmask0=1.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_next[i] = r_mem[i];
            if (w_wen1 && (bus.waddr1 == ADDR_BITS'(i))) begin
                w_next[i] = bus.wdata1;
            end
            if (w_wen0 && (bus.waddr0 == ADDR_BITS'(i))) begin
                w_next[i] = (w_next[i] & ~bus.wmask0) | (bus.wdata0 & bus.wmask0);
            end
        end
    end

    // Read source per entry: next value when bypassing, stored value otherwise.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_view[i] = BYPASS ? w_next[i] : r_mem[i];
        end
    end

    // Read mux A; out-of-range addresses match no entry and return zero.
    always_comb begin
        w_rdata_a = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (bus.raddr_a == ADDR_BITS'(i)) begin
                w_rdata_a = w_view[i];
            end
        end
    end

    // Read mux B; same structure as A.
    always_comb begin
        w_rdata_b = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (bus.raddr_b == ADDR_BITS'(i)) begin
                w_rdata_b = w_view[i];
            end
        end
    end

    // Next-cycle status flags.
    always_comb begin
        w_collision = w_wen0 & w_wen1 & (bus.waddr0 == bus.waddr1);
        w_oob       = (bus.we0 & ~w_in0) | (bus.we1 & ~w_in1) | ~w_in_a | ~w_in_b;
    end

    // Storage array with asynchronous reset to RESET_VALUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= w_next[i];
            end
        end
    end

    // Status flops, one-cycle delayed views of collision and out-of-range use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_collision <= 1'b0;
            r_oob_err   <= 1'b0;
        end else begin
            r_collision <= w_collision;
            r_oob_err   <= w_oob;
        end
    end

    assign bus.rdata_a   = w_rdata_a;
    assign bus.rdata_b   = w_rdata_b;
    assign bus.collision = r_collision;
    assign bus.oob_err   = r_oob_err;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: a full-depth bypassing instance and a depth-3
// non-bypassing instance driven with identical stimulus against a model.
`timescale 1ns/100ps
module tb_regfile_2w2r;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_2w2r_if #(.WIDTH(8), .ADDR_BITS(2)) bus_a ();
    regfile_2w2r_if #(.WIDTH(8), .ADDR_BITS(2)) bus_b ();

    regfile_2w2r #(
        .WIDTH(8), .ADDR_BITS(2), .DEPTH(4), .BYPASS(1'b1), .RESET_VALUE(8'h5A)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    regfile_2w2r #(
        .WIDTH(8), .ADDR_BITS(2), .DEPTH(3), .BYPASS(1'b0), .RESET_VALUE(8'h5A)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Shared stimulus
    logic       s_we0, s_we1;
    logic [1:0] s_waddr0, s_waddr1, s_raddr_a, s_raddr_b;
    logic [7:0] s_wdata0, s_wmask0, s_wdata1;

    assign bus_a.we0 = s_we0;       assign bus_b.we0 = s_we0;
    assign bus_a.waddr0 = s_waddr0; assign bus_b.waddr0 = s_waddr0;
    assign bus_a.wdata0 = s_wdata0; assign bus_b.wdata0 = s_wdata0;
    assign bus_a.wmask0 = s_wmask0; assign bus_b.wmask0 = s_wmask0;
    assign bus_a.we1 = s_we1;       assign bus_b.we1 = s_we1;
    assign bus_a.waddr1 = s_waddr1; assign bus_b.waddr1 = s_waddr1;
    assign bus_a.wdata1 = s_wdata1; assign bus_b.wdata1 = s_wdata1;
    assign bus_a.raddr_a = s_raddr_a; assign bus_b.raddr_a = s_raddr_a;
    assign bus_a.raddr_b = s_raddr_b; assign bus_b.raddr_b = s_raddr_b;

    // Reference model: index 0 = DUT A (depth 4, bypass), 1 = DUT B (depth 3)
    logic [7:0] mem [2][4];
    int         dep [2];
    bit         byp [2];

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t q_exp[$];

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] next_val(input int c, input int idx);
        logic [7:0] v;
        v = mem[c][idx];
        if (reset || idx >= dep[c]) return v;
        if (s_we1 && int'(s_waddr1) == idx) v = s_wdata1;
        if (s_we0 && int'(s_waddr0) == idx) v = (v & ~s_wmask0) | (s_wdata0 & s_wmask0);
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input int c, input logic [1:0] ra);
        if (int'(ra) >= dep[c]) return 8'h00;
        if (byp[c]) return next_val(c, int'(ra));
        return mem[c][ra];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4; i++) mem[c][i] = 8'h5A;
    endtask

    task automatic push_reads(input string tag);
        for (int c = 0; c < 2; c++) begin
            q_exp.push_back('{tag: $sformatf("%s_rda%0d", tag, c), val: exp_rd(c, s_raddr_a)});
            q_exp.push_back('{tag: $sformatf("%s_rdb%0d", tag, c), val: exp_rd(c, s_raddr_b)});
        end
    endtask

    task automatic pop_cmp(input logic [7:0] obs);
        exp_t e;
        e = q_exp.pop_front();
        check_val(e.tag, obs, e.val);
    endtask

    task automatic pop_reads();
        pop_cmp(bus_a.rdata_a);
        pop_cmp(bus_a.rdata_b);
        pop_cmp(bus_b.rdata_a);
        pop_cmp(bus_b.rdata_b);
    endtask

    task automatic check_now(input string tag);
        push_reads(tag);
        #1;
        pop_reads();
    endtask

    // One clock: check combinational reads, take the edge, check the flags.
    task automatic step(input string tag);
        logic [7:0] nv [2][4];
        logic       col, oob;
        check_now(tag);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            col = !reset && s_we0 && s_we1 && (s_waddr0 == s_waddr1) && (int'(s_waddr0) < dep[c]);
            oob = !reset && ((s_we0 && int'(s_waddr0) >= dep[c]) ||
                             (s_we1 && int'(s_waddr1) >= dep[c]) ||
                             (int'(s_raddr_a) >= dep[c]) || (int'(s_raddr_b) >= dep[c]));
            q_exp.push_back('{tag: $sformatf("%s_col%0d", tag, c), val: {7'd0, col}});
            q_exp.push_back('{tag: $sformatf("%s_oob%0d", tag, c), val: {7'd0, oob}});
            for (int i = 0; i < 4; i++) nv[c][i] = reset ? 8'h5A : next_val(c, i);
        end
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4; i++) mem[c][i] = nv[c][i];
        #1;
        pop_cmp({7'd0, bus_a.collision});
        pop_cmp({7'd0, bus_a.oob_err});
        pop_cmp({7'd0, bus_b.collision});
        pop_cmp({7'd0, bus_b.oob_err});
        @(negedge clk);
    endtask

    task automatic idle();
        s_we0 = 0; s_we1 = 0; s_wmask0 = 8'h00; s_wdata0 = 8'h00; s_wdata1 = 8'h00;
        s_waddr0 = 2'd0; s_waddr1 = 2'd0;
    endtask

    task automatic wr1(input logic [1:0] a, input logic [7:0] d);
        idle();
        s_we1 = 1; s_waddr1 = a; s_wdata1 = d;
    endtask

    initial begin
        dep[0] = 4; dep[1] = 3;
        byp[0] = 1; byp[1] = 0;
        model_reset();
        idle();
        s_raddr_a = 2'd0; s_raddr_b = 2'd0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fill, then end on a colliding cycle with an out-of-range read
        wr1(2'd0, 8'h11); step("fill0");
        wr1(2'd1, 8'h22); step("fill1");
        wr1(2'd2, 8'h33); step("fill2");
        wr1(2'd3, 8'h44); step("fill3");
        idle();
        s_we0 = 1; s_we1 = 1; s_wmask0 = 8'hFF; s_wdata0 = 8'hE1; s_wdata1 = 8'hE2;
        s_raddr_b = 2'd3;
        step("precol");

        // Asynchronous reset between edges
        idle();
        s_raddr_b = 2'd0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_val("async_col0", {7'd0, bus_a.collision}, 8'h00);
        check_val("async_oob1", {7'd0, bus_b.oob_err}, 8'h00);
        check_val("async_col1", {7'd0, bus_b.collision}, 8'h00);
        for (int r = 0; r < 4; r++) begin
            s_raddr_a = 2'(r);
            check_now($sformatf("async_rd%0d", r));
        end
        @(negedge clk);
        reset = 1'b0;
        s_raddr_a = 2'd0;

        // Masked write and zero-mask write
        s_raddr_a = 2'd2; s_raddr_b = 2'd2;
        wr1(2'd2, 8'hF0); step("mask_pre");
        idle();
        s_we0 = 1; s_waddr0 = 2'd2; s_wdata0 = 8'h0F; s_wmask0 = 8'h3C;
        step("mask_wr");
        idle(); step("mask_rd");
        s_we0 = 1; s_waddr0 = 2'd2; s_wdata0 = 8'hFF; s_wmask0 = 8'h00;
        step("mask_zero");
        idle(); step("mask_zero_rd");

        // Same-address dual write, then two consecutive collisions
        s_raddr_a = 2'd1; s_raddr_b = 2'd1;
        s_we0 = 1; s_we1 = 1; s_waddr0 = 2'd1; s_waddr1 = 2'd1;
        s_wdata0 = 8'hFF; s_wmask0 = 8'h81; s_wdata1 = 8'h00;
        step("dual");
        idle(); step("dual_after");
        s_we0 = 1; s_we1 = 1; s_waddr0 = 2'd0; s_waddr1 = 2'd0;
        s_wdata0 = 8'h12; s_wmask0 = 8'h0F; s_wdata1 = 8'hA0;
        step("col_x1");
        s_wdata0 = 8'h34; s_wdata1 = 8'hB0;
        step("col_x2");
        idle(); step("col_end");

        // Bypass vs registered read
        s_raddr_a = 2'd3; s_raddr_b = 2'd2;
        s_we1 = 1; s_waddr1 = 2'd3; s_wdata1 = 8'hAB;
        s_we0 = 1; s_waddr0 = 2'd2; s_wdata0 = 8'hAB; s_wmask0 = 8'hFF;
        step("byp_wr");
        idle(); step("byp_rd");

        // Out of range on the depth-3 instance
        s_raddr_a = 2'd0; s_raddr_b = 2'd3;
        wr1(2'd3, 8'h77); step("oob_w1");
        idle(); s_raddr_b = 2'd0;
        s_we0 = 1; s_waddr0 = 2'd3; s_wdata0 = 8'h66; s_wmask0 = 8'hFF;
        step("oob_w0");
        idle(); s_raddr_a = 2'd3; s_raddr_b = 2'd2;
        step("oob_rd");
        idle(); s_raddr_a = 2'd0; s_raddr_b = 2'd1;
        step("oob_clear");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            s_we0 = 1'($urandom); s_we1 = 1'($urandom);
            s_waddr0 = 2'($urandom); s_waddr1 = 2'($urandom);
            s_wdata0 = 8'($urandom); s_wmask0 = 8'($urandom); s_wdata1 = 8'($urandom);
            s_raddr_a = 2'($urandom); s_raddr_b = 2'($urandom);
            step($sformatf("rnd%0d", n));
        end

        // Reset pulse during back-to-back writes
        wr1(2'd1, 8'hC1); step("b2b0");
        wr1(2'd2, 8'hC2); step("b2b1");
        wr1(2'd0, 8'hC3);
        s_raddr_a = 2'd0; s_raddr_b = 2'd2;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_now("mid_rst");
        step("mid_rst_hold");
        reset = 1'b0;
        idle();
        s_we0 = 1; s_waddr0 = 2'd1; s_wdata0 = 8'h99; s_wmask0 = 8'hFF;
        s_raddr_a = 2'd1; s_raddr_b = 2'd0;
        step("post_rst_wr");
        idle();
        s_raddr_a = 2'd0; s_raddr_b = 2'd1; step("post_rd01");
        s_raddr_a = 2'd2; s_raddr_b = 2'd3; step("post_rd23");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout: run exceeded 100000 ns, expected completion");
        $fatal(1);
    end

endmodule
